rupt_priority_sequencer: RTL and testbench

- Schedules program interrupts (RUPTs) into the SQ register's forced-RUPT path.
- Latches pulse requests from up to NREQ rupt sources and arbitrates them by fixed priority.
- At an instruction boundary permitted by the SQ register's RPTSET, grants one source: emits a KRPT acknowledge plus the vector index and address, then blocks further grants until RESUME.
- Drives RUPTOR_n back to the SQ register.

---
 rtl/rupt_priority_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_rupt_priority_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rupt_priority_sequencer.sv
// ============================================================================
// rupt_priority_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//    Schedules program interrupts (RUPTs) into the SQ register's forced-RUPT
//    path. Each source raises a pulse on its RUPT_REQ line. The rising edge
//    latches a pending bit. At an end-of-MCT strobe (T12) that the SQ register
//    permits (RPTSET), the lowest-numbered pending source is granted: a
//    one-cycle KRPT acknowledge is issued with the vector index and vector
//    address. No further grants are made until the RESUME instruction ends
//    the rupt.
//
// Parameters:
//    NREQ        number of rupt sources (1..15). Index 0 has the highest
//                priority (T6RUPT).
//    LOCK_LIMIT  number of T12 strobes a rupt may stay active before the
//                rupt-lock alarm is raised. Used only when RUPT_LOCK_EN is
//                defined.
//
// Optional feature (compile-time macro):
//    RUPT_LOCK_EN  Enables the rupt-lock watchdog counter and alarm. When
//                  the macro is undefined, RPTLOCK_ALM is tied low.
//
// Ports:
//    SIM_CLK      in   1     single clock of the block
//    SIM_RST      in   1     asynchronous, active-low reset
//    GOJAM        in   1     synchronous restart (clears pending, state, alarm)
//    RUPT_REQ     in   NREQ  request lines, rising-edge sensitive
//    T12          in   1     one-cycle end-of-MCT strobe
//    RPTSET       in   1     SQ register permits a rupt at this boundary
//    MNHRPT       in   1     monitor inhibit of grants
//    RESUME       in   1     one-cycle strobe, the rupt has ended
//    KRPT         out  1     one-cycle grant pulse
//    RUPTOR_n     out  1     low while any request is pending
//    RUPT_VEC     out  4     index of the last granted source
//    RUPT_ADDR    out  12    vector address of the last grant
//    RUPT_ACTIVE  out  1     high from grant until RESUME
//    PENDING      out  NREQ  pending bit vector
//    RPTLOCK_ALM  out  1     sticky rupt-lock alarm
// ============================================================================
module rupt_priority_sequencer #(
   parameter int NREQ       = 10,
   parameter int LOCK_LIMIT = 140
) (
   input  logic            SIM_CLK,
   input  logic            SIM_RST,
   input  logic            GOJAM,
   input  logic [NREQ-1:0] RUPT_REQ,
   input  logic            T12,
   input  logic            RPTSET,
   input  logic            MNHRPT,
   input  logic            RESUME,
   output logic            KRPT,
   output logic            RUPTOR_n,
   output logic [3:0]      RUPT_VEC,
   output logic [11:0]     RUPT_ADDR,
   output logic            RUPT_ACTIVE,
   output logic [NREQ-1:0] PENDING,
   output logic            RPTLOCK_ALM
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t          state;
   logic [NREQ-1:0] req_prev;
   logic [NREQ-1:0] pend;
   logic [NREQ-1:0] req_rise;
   logic [NREQ-1:0] win_mask;
   logic [NREQ-1:0] clr_mask;
   logic [3:0]      win_idx;
   logic [11:0]     win_addr;
   logic            grant_fire;

   // Rising-edge detection on every request line. req_prev starts at zero,
   // so a line already high when reset is released counts as a request.
   always_comb begin
      req_rise = RUPT_REQ & ~req_prev;
   end

   // Fixed-priority encoder over the registered pending bits. Scanning from
   // the top index down lets the lowest set index overwrite, so it wins.
   always_comb begin
      win_idx  = '0;
      win_mask = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (pend[i]) begin
            win_idx     = 4'(i);
            win_mask    = '0;
            win_mask[i] = 1'b1;
         end
      end
   end

   // A grant fires only from IDLE, at a permitted T12 boundary, with the
   // monitor not inhibiting and something registered as pending. Requests
   // whose edge arrives in this same cycle are not yet in pend, so they wait
   // for the next T12.
   always_comb begin
      grant_fire = (state == IDLE) && T12 && RPTSET && !MNHRPT && (|pend);
      clr_mask   = grant_fire ? win_mask : '0;
      win_addr   = 12'o4000 + (({8'd0, win_idx} + 12'd1) << 2);
   end

   // Pending-bit bookkeeping. The granted bit is cleared, but a fresh edge on
   // the same source in that cycle sets it again, so the set term is applied
   // last. GOJAM drops every pending bit. req_prev keeps tracking the lines,
   // so lines held high through GOJAM do not trigger again afterwards.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         req_prev <= '0;
         pend     <= '0;
      end else begin
         req_prev <= RUPT_REQ;
         if (GOJAM) begin
            pend <= '0;
         end else begin
            pend <= (pend & ~clr_mask) | req_rise;
         end
      end
   end

   // Grant sequencer with registered outputs. KRPT, RUPT_VEC, RUPT_ADDR and
   // RUPT_ACTIVE are loaded on the edge that enters GRANT, which places KRPT
   // one cycle after the T12 that won arbitration. A RESUME seen in GRANT is
   // honoured at once, and the sequencer returns to IDLE and skips ACTIVE.
   // GOJAM returns to IDLE but leaves the last vector and address visible.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state       <= IDLE;
         KRPT        <= 1'b0;
         RUPT_VEC    <= 4'd0;
         RUPT_ADDR   <= 12'o4004;
         RUPT_ACTIVE <= 1'b0;
      end else if (GOJAM) begin
         state       <= IDLE;
         KRPT        <= 1'b0;
         RUPT_ACTIVE <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               KRPT <= 1'b0;
               if (grant_fire) begin
                  state       <= GRANT;
                  KRPT        <= 1'b1;
                  RUPT_VEC    <= win_idx;
                  RUPT_ADDR   <= win_addr;
                  RUPT_ACTIVE <= 1'b1;
               end
            end
            GRANT: begin
               KRPT <= 1'b0;
               if (RESUME) begin
                  state       <= IDLE;
                  RUPT_ACTIVE <= 1'b0;
               end else begin
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               KRPT <= 1'b0;
               if (RESUME) begin
                  state       <= IDLE;
                  RUPT_ACTIVE <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               KRPT        <= 1'b0;
               RUPT_ACTIVE <= 1'b0;
            end
         endcase
      end
   end

   // The SQ register sees a single "something is pending" line, active low.
   assign RUPTOR_n = ~(|pend);
   assign PENDING  = pend;

`ifdef RUPT_LOCK_EN
   localparam int LockW = (LOCK_LIMIT < 1) ? 1 : $clog2(LOCK_LIMIT + 1);

   logic [LockW-1:0] lock_cnt;
   logic             lock_alm;

   // Rupt-lock watchdog. Counts T12 strobes while a rupt is active. A rupt
   // that never issues RESUME eventually raises a sticky alarm. The counter
   // saturates at the limit, and only GOJAM or reset clears the alarm.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         lock_cnt <= '0;
         lock_alm <= 1'b0;
      end else if (GOJAM) begin
         lock_cnt <= '0;
         lock_alm <= 1'b0;
      end else if (RESUME) begin
         lock_cnt <= '0;
      end else if (T12 && RUPT_ACTIVE && (lock_cnt != LockW'(LOCK_LIMIT))) begin
         lock_cnt <= lock_cnt + LockW'(1);
         if (lock_cnt == LockW'(LOCK_LIMIT - 1)) begin
            lock_alm <= 1'b1;
         end
      end
   end

   assign RPTLOCK_ALM = lock_alm;
`else
   // The watchdog is not built. The limit is referenced only so that it is
   // not reported as an unused parameter.
   logic unused_lock_cfg;
   assign unused_lock_cfg = (LOCK_LIMIT > 0);
   assign RPTLOCK_ALM     = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_priority_sequencer.sv
// ============================================================================
// tb_rupt_priority_sequencer
// ----------------------------------------------------------------------------
// Directed, table-driven bench for rupt_priority_sequencer (NREQ=10,
// LOCK_LIMIT=4). Each table row holds the inputs for one clock cycle and the
// outputs expected just after that cycle's rising edge. Hand-written
// sequences cover the rupt-lock alarm, GOJAM, the asynchronous reset in the
// middle of a grant, and a line that is held high across reset release.
// ============================================================================
module tb_rupt_priority_sequencer;

   localparam int NREQ = 10;

`ifdef RUPT_LOCK_EN
   localparam logic LockEn = 1'b1;
`else
   localparam logic LockEn = 1'b0;
`endif

   logic            SIM_CLK = 1'b0;
   logic            SIM_RST = 1'b0;
   logic            GOJAM = 1'b0;
   logic [NREQ-1:0] RUPT_REQ = '0;
   logic            T12 = 1'b0;
   logic            RPTSET = 1'b0;
   logic            MNHRPT = 1'b0;
   logic            RESUME = 1'b0;
   logic            KRPT;
   logic            RUPTOR_n;
   logic [3:0]      RUPT_VEC;
   logic [11:0]     RUPT_ADDR;
   logic            RUPT_ACTIVE;
   logic [NREQ-1:0] PENDING;
   logic            RPTLOCK_ALM;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NREQ-1:0] req;
      logic            t12;
      logic            rpt;
      logic            mn;
      logic            res;
      logic            gj;
      logic            krpt;
      logic            rn;
      logic [3:0]      vec;
      logic [11:0]     addr;
      logic            act;
      logic [NREQ-1:0] pend;
   } vec_t;

   vec_t tbl[$];

   rupt_priority_sequencer #(
      .NREQ       (NREQ),
      .LOCK_LIMIT (4)
   ) dut (
      .SIM_CLK     (SIM_CLK),
      .SIM_RST     (SIM_RST),
      .GOJAM       (GOJAM),
      .RUPT_REQ    (RUPT_REQ),
      .T12         (T12),
      .RPTSET      (RPTSET),
      .MNHRPT      (MNHRPT),
      .RESUME      (RESUME),
      .KRPT        (KRPT),
      .RUPTOR_n    (RUPTOR_n),
      .RUPT_VEC    (RUPT_VEC),
      .RUPT_ADDR   (RUPT_ADDR),
      .RUPT_ACTIVE (RUPT_ACTIVE),
      .PENDING     (PENDING),
      .RPTLOCK_ALM (RPTLOCK_ALM)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   function automatic vec_t mk(input logic [NREQ-1:0] req, input logic t12,
                               input logic rpt, input logic mn, input logic res,
                               input logic gj, input logic krpt, input logic rn,
                               input logic [3:0] vec, input logic [11:0] addr,
                               input logic act, input logic [NREQ-1:0] pend);
      vec_t v;
      v.req = req; v.t12 = t12; v.rpt = rpt; v.mn = mn; v.res = res; v.gj = gj;
      v.krpt = krpt; v.rn = rn; v.vec = vec; v.addr = addr; v.act = act;
      v.pend = pend;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] req, input logic t12,
                                input logic rpt, input logic mn,
                                input logic res, input logic gj);
      RUPT_REQ = req;
      T12      = t12;
      RPTSET   = rpt;
      MNHRPT   = mn;
      RESUME   = res;
      GOJAM    = gj;
      @(posedge SIM_CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic krpt, input logic rn,
                              input logic [3:0] vec, input logic [11:0] addr,
                              input logic act, input logic [NREQ-1:0] pend);
      checkVal({tag, " KRPT"}, 32'(KRPT), 32'(krpt));
      checkVal({tag, " RUPTOR_n"}, 32'(RUPTOR_n), 32'(rn));
      checkVal({tag, " RUPT_VEC"}, 32'(RUPT_VEC), 32'(vec));
      checkVal({tag, " RUPT_ADDR"}, 32'(RUPT_ADDR), 32'(addr));
      checkVal({tag, " RUPT_ACTIVE"}, 32'(RUPT_ACTIVE), 32'(act));
      checkVal({tag, " PENDING"}, 32'(PENDING), 32'(pend));
   endtask

   initial begin
      // Columns: req t12 rpt mn res gj | krpt rn vec addr act pend
      // Single source 3, grant at T12, then held off while active.
      tbl.push_back(mk(10'h008,0,0,0,0,0, 0,0,4'd0,12'o4004,0,10'h008));
      tbl.push_back(mk(10'h000,0,0,0,0,0, 0,0,4'd0,12'o4004,0,10'h008));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd3,12'o4020,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,0,0, 0,1,4'd3,12'o4020,1,10'h000));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 0,1,4'd3,12'o4020,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd3,12'o4020,0,10'h000));
      // Sources 7 and 2 together: 2 wins, RESUME in GRANT, then 7.
      tbl.push_back(mk(10'h084,0,0,0,0,0, 0,0,4'd3,12'o4020,0,10'h084));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,0,4'd2,12'o4014,1,10'h080));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,0,4'd2,12'o4014,0,10'h080));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd7,12'o4040,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,0,0, 0,1,4'd7,12'o4040,1,10'h000));
      // Source 0 while active: five permitted strobes, no grant.
      tbl.push_back(mk(10'h001,0,0,0,0,0, 0,0,4'd7,12'o4040,1,10'h001));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(10'h000,1,1,0,0,0, 0,0,4'd7,12'o4040,1,10'h001));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,0,4'd7,12'o4040,0,10'h001));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd0,12'o4004,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd0,12'o4004,0,10'h000));
      // Source 4: T12 without RPTSET, then monitor inhibit, then grant.
      tbl.push_back(mk(10'h010,0,0,0,0,0, 0,0,4'd0,12'o4004,0,10'h010));
      tbl.push_back(mk(10'h000,1,0,0,0,0, 0,0,4'd0,12'o4004,0,10'h010));
      tbl.push_back(mk(10'h000,1,1,1,0,0, 0,0,4'd0,12'o4004,0,10'h010));
      tbl.push_back(mk(10'h000,1,1,1,0,0, 0,0,4'd0,12'o4004,0,10'h010));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd4,12'o4024,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd4,12'o4024,0,10'h000));
      // Source 5 edge in the T12 cycle itself: eligible only next T12.
      tbl.push_back(mk(10'h020,1,1,0,0,0, 0,0,4'd4,12'o4024,0,10'h020));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd5,12'o4030,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd5,12'o4030,0,10'h000));
      // Source 1: a fresh edge in the grant cycle keeps the bit set.
      tbl.push_back(mk(10'h002,0,0,0,0,0, 0,0,4'd5,12'o4030,0,10'h002));
      tbl.push_back(mk(10'h000,0,0,0,0,0, 0,0,4'd5,12'o4030,0,10'h002));
      tbl.push_back(mk(10'h002,1,1,0,0,0, 1,0,4'd1,12'o4010,1,10'h002));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,0,4'd1,12'o4010,0,10'h002));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd1,12'o4010,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd1,12'o4010,0,10'h000));
      // RESUME while idle is ignored. The top source (9) is granted.
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd1,12'o4010,0,10'h000));
      tbl.push_back(mk(10'h200,0,0,0,0,0, 0,0,4'd1,12'o4010,0,10'h200));
      tbl.push_back(mk(10'h000,1,1,0,0,0, 1,1,4'd9,12'o4050,1,10'h000));
      tbl.push_back(mk(10'h000,0,0,0,1,0, 0,1,4'd9,12'o4050,0,10'h000));

      // Reset values while SIM_RST is held low.
      repeat (3) @(posedge SIM_CLK);
      #1;
      checkOutput("reset", 0, 1, 4'd0, 12'o4004, 0, '0);
      checkVal("reset RPTLOCK_ALM", 32'(RPTLOCK_ALM), 32'd0);
      SIM_RST = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         applyStimulus(tbl[r].req, tbl[r].t12, tbl[r].rpt, tbl[r].mn,
                       tbl[r].res, tbl[r].gj);
         checkOutput($sformatf("row%0d", r), tbl[r].krpt, tbl[r].rn,
                     tbl[r].vec, tbl[r].addr, tbl[r].act, tbl[r].pend);
      end

      // Rupt-lock alarm: grant source 8, then four strobes with no RESUME.
      applyStimulus(10'h100, 0, 0, 0, 0, 0);
      applyStimulus(10'h000, 1, 1, 0, 0, 0);
      checkOutput("lock grant", 1, 1, 4'd8, 12'o4044, 1, '0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'h000, 1, 1, 0, 0, 0);
         checkVal($sformatf("lock t12_%0d alarm", i + 1), 32'(RPTLOCK_ALM), 32'd0);
      end
      applyStimulus(10'h000, 1, 1, 0, 0, 0);
      checkVal("lock t12_4 alarm", 32'(RPTLOCK_ALM), 32'(LockEn));
      applyStimulus(10'h000, 0, 0, 0, 1, 0);
      checkVal("lock after resume", 32'(RPTLOCK_ALM), 32'(LockEn));
      checkVal("lock after resume active", 32'(RUPT_ACTIVE), 32'd0);
      applyStimulus(10'h000, 0, 0, 0, 0, 1);
      checkVal("lock after gojam", 32'(RPTLOCK_ALM), 32'd0);

      // GOJAM while active with sources 1 and 5 pending.
      applyStimulus(10'h040, 0, 0, 0, 0, 0);
      applyStimulus(10'h000, 1, 1, 0, 0, 0);
      checkOutput("gj grant", 1, 1, 4'd6, 12'o4034, 1, '0);
      applyStimulus(10'h000, 0, 0, 0, 0, 0);
      applyStimulus(10'h022, 0, 0, 0, 0, 0);
      checkOutput("gj pend", 0, 0, 4'd6, 12'o4034, 1, 10'h022);
      applyStimulus(10'h122, 0, 0, 0, 0, 1);
      checkOutput("gj clear", 0, 1, 4'd6, 12'o4034, 0, '0);
      applyStimulus(10'h122, 1, 1, 0, 0, 0);
      checkOutput("gj held lines", 0, 1, 4'd6, 12'o4034, 0, '0);
      applyStimulus(10'h000, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a grant.
      applyStimulus(10'h008, 0, 0, 0, 0, 0);
      applyStimulus(10'h000, 1, 1, 0, 0, 0);
      checkOutput("arst pre", 1, 1, 4'd3, 12'o4020, 1, '0);
      RUPT_REQ = 10'h001;
      T12      = 1'b0;
      RPTSET   = 1'b0;
      #1;
      SIM_RST = 1'b0;
      #1;
      checkOutput("arst async", 0, 1, 4'd0, 12'o4004, 0, '0);
      checkVal("arst RPTLOCK_ALM", 32'(RPTLOCK_ALM), 32'd0);
      @(posedge SIM_CLK);
      #1;
      SIM_RST = 1'b1;
      // Line 0 was high throughout reset: it registers on the first edge.
      applyStimulus(10'h001, 0, 0, 0, 0, 0);
      checkOutput("held at release", 0, 0, 4'd0, 12'o4004, 0, 10'h001);
      applyStimulus(10'h001, 1, 1, 0, 0, 0);
      checkOutput("held grant", 1, 1, 4'd0, 12'o4004, 1, '0);
      applyStimulus(10'h000, 0, 0, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
